// File: rtl/div_sched_pkg.sv
// Shared types and constants for the div_sched round-robin divider scheduler.
package div_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 16;

  localparam logic [DATA_W_DEF-1:0] QUO_POS_SAT = 16'h7FFF;
  localparam logic [DATA_W_DEF-1:0] QUO_NEG_SAT = 16'h8000;

  // Index width for a counter/pointer covering n values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W_DEF = idx_w(4);
  localparam int CNT_W_DEF = idx_w(2);

endpackage

// File: rtl/div_sched_divider.sv
// Combinational signed divider: restoring division on magnitudes, then sign fix-up
// (quotient truncates toward zero, remainder takes the dividend's sign).
module div_sched_divider #(
  parameter int input_width = 16
) (
  input  logic [input_width-1:0] dividend,
  input  logic [input_width-1:0] divisor,
  output logic [input_width-1:0] quotient,
  output logic [input_width-1:0] remainder
);

  localparam int W = input_width;

  logic [W-1:0] a_mag_s;
  logic [W-1:0] b_mag_s;
  logic [W-1:0] q_mag_s;
  logic [W:0]   r_acc_s;

  always_comb begin
    a_mag_s = dividend[W-1] ? (~dividend + 1'b1) : dividend;
    b_mag_s = divisor[W-1]  ? (~divisor + 1'b1)  : divisor;
    q_mag_s = '0;
    r_acc_s = '0;
    for (int i = W - 1; i >= 0; i--) begin
      r_acc_s = {r_acc_s[W-1:0], a_mag_s[i]};
      if (r_acc_s >= {1'b0, b_mag_s}) begin
        r_acc_s    = r_acc_s - {1'b0, b_mag_s};
        q_mag_s[i] = 1'b1;
      end else begin
        q_mag_s[i] = 1'b0;
      end
    end
    quotient  = (dividend[W-1] ^ divisor[W-1]) ? (~q_mag_s + 1'b1) : q_mag_s;
    remainder = dividend[W-1] ? (~r_acc_s[W-1:0] + 1'b1) : r_acc_s[W-1:0];
  end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one multicycle combinational divider among NUM_REQ requesters.
// Optional divide-by-zero short-cut with saturated quotient: define DIV_SCHED_DIVZERO_EN.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_q,
  input  logic [NUM_REQ*DATA_W-1:0] req_m,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_quo,
  output logic [DATA_W-1:0]         rsp_rem,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int PTR_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(SETTLE_CYCLES);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  op_q_q, op_q_d;
  logic [DATA_W-1:0]  op_m_q, op_m_d;
  logic [DATA_W-1:0]  quo_q, quo_d;
  logic [DATA_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0]  div_quo_s, div_rem_s;
  logic [DATA_W-1:0]  gnt_q_s, gnt_m_s;
  logic [PTR_W-1:0]   gnt_s, idx_s;
  logic [PTR_W:0]     sum_s;
  logic               gnt_vld_s, hit_s;
`ifdef DIV_SCHED_DIVZERO_EN
  logic               err_q, err_d;
`endif

  div_sched_divider #(.input_width(DATA_W)) u_divider (
    .dividend  (op_q_q),
    .divisor   (op_m_q),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_s     = '0;
    sum_s     = '0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s     = {1'b0, ptr_q} + (PTR_W+1)'(k);
      sum_s     = (sum_s >= (PTR_W+1)'(NUM_REQ)) ? (sum_s - (PTR_W+1)'(NUM_REQ)) : sum_s;
      idx_s     = sum_s[PTR_W-1:0];
      hit_s     = !gnt_vld_s && req_valid[idx_s];
      gnt_s     = hit_s ? idx_s : gnt_s;
      gnt_vld_s = gnt_vld_s | hit_s;
    end
  end

  assign gnt_q_s = req_q[int'(gnt_s)*DATA_W +: DATA_W];
  assign gnt_m_s = req_m[int'(gnt_s)*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    op_q_d    = op_q_q;
    op_m_d    = op_m_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
`ifdef DIV_SCHED_DIVZERO_EN
    err_d     = err_q;
`endif
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld_s) begin
          req_ready[gnt_s] = 1'b1;
          op_q_d  = gnt_q_s;
          op_m_d  = gnt_m_s;
          owner_d = gnt_s;
          ptr_d   = (gnt_s == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_s + 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
`ifdef DIV_SCHED_DIVZERO_EN
          if (gnt_m_s == '0) begin
            quo_d   = gnt_q_s[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
            rem_d   = gnt_q_s;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Divider inputs have been stable for the full settle window at this edge.
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          quo_d   = div_quo_s;
          rem_d   = div_rem_s;
`ifdef DIV_SCHED_DIVZERO_EN
          err_d   = 1'b0;
`endif
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      op_q_q  <= '0;
      op_m_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_SCHED_DIVZERO_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      op_q_q  <= op_q_d;
      op_m_q  <= op_m_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_SCHED_DIVZERO_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end else begin
      rsp_valid = '0;
    end
  end

  assign rsp_quo = quo_q;
  assign rsp_rem = rem_q;
  assign busy    = (state_q != ST_IDLE);
`ifdef DIV_SCHED_DIVZERO_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
Round-robin scheduler that shares one combinational signed 16-bit divider between NUM_REQ feature-extraction requesters, such as the mean, variance and line-length normalisers in the seizure-detection pipeline.
- Arbitrates requests and registers the operands.
- Holds the divider inputs stable for a fixed multicycle settle window.
- Captures quotient and remainder and returns them to the winning requester over a valid/ready response handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand/result width; two's complement.
- SETTLE_CYCLES, 2, cycles the divider inputs are held before capture (>=1); matches the multicycle constraint on the divider.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot accept.
- req_q  in  NUM_REQ*DATA_W  dividends; slice i belongs to requester i.
- req_m  in  NUM_REQ*DATA_W  divisors; slice i belongs to requester i.
- rsp_valid  out  NUM_REQ  one-hot result valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_quo  out  DATA_W  signed quotient, truncated toward zero.
- rsp_rem  out  DATA_W  signed remainder; sign follows the dividend.
- rsp_err  out  1  divide-by-zero flag; only driven when the optional feature is enabled, else 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: single clock; rst is synchronous and active-high.
  - Reset, including mid-operation, forces state to IDLE and the RR pointer to 0.
  - All outputs are 0 after reset; any in-flight result is discarded without a response.
- States:
  - IDLE: grant = first i with req_valid[i], searching from ptr upward with wrap-around. req_ready[grant] is combinational and asserted in this state only. On acceptance: latch req_q/req_m slices into op_q/op_m, record owner = grant, set ptr = grant+1 mod NUM_REQ, cnt = 0, go to WAIT. No valid request: stay in IDLE, ptr unchanged.
  - WAIT: divider inputs are driven only from op_q/op_m. cnt increments each cycle. At the edge where cnt == SETTLE_CYCLES-1, register divider outputs into rsp_quo/rsp_rem and go to RESP.
  - RESP: rsp_valid[owner] = 1. rsp_quo, rsp_rem and rsp_err are held stable until rsp_ready[owner]. On that handshake edge go to IDLE and clear rsp_valid. rsp_ready of non-owners is ignored.
- Latency: accept at edge E0 -> rsp_valid high after edge E0+SETTLE_CYCLES. Next acceptance is possible at the edge after the response handshake (minimum 1 IDLE cycle).
- Simultaneous requests: exactly one grant per IDLE cycle; the rest wait with req_valid held. Requests arriving in WAIT/RESP see req_ready = 0.
- Requester rules: requesters keep req_valid and operands stable until accepted; dropping req_valid before acceptance simply removes the requester from arbitration.
- Arithmetic: the divider is a combinational restoring divider on magnitudes with sign fix-up.
  - quo sign = sign(Q) xor sign(M).
  - rem sign = sign(Q).
  - -32768 operands wrap modulo 2^DATA_W; no saturation.

Optional Feature:
DIV_SCHED_DIVZERO_EN
- Defined: op_m == 0 is checked at acceptance and WAIT is skipped; the block enters RESP on the next edge with:
  - rsp_err = 1
  - rsp_quo = 0x7FFF if op_q >= 0, else 0x8000
  - rsp_rem = op_q
- Undefined: divisor 0 is handled like any other divisor; raw divider output is returned after the full settle window and rsp_err is tied to 0.

Decomposition:
- Package div_sched_pkg:
  - state enum (IDLE, WAIT, RESP)
  - DATA_W default
  - saturation constants QUO_POS_SAT / QUO_NEG_SAT
  - clog2-based widths for ptr and cnt
- Sub-module: instantiate the existing combinational divider (parameter input_width = DATA_W) as u_divider. The arbiter logic stays inline; no separate arbiter module.

Test Plan:
- Single request: requester 0, Q=100, M=7 -> req_ready[0] same cycle; rsp_valid[0] after 2 edges; quo=14, rem=2.
- Signed corners, with response checks:
  - -7/2 -> quo=0xFFFD, rem=0xFFFF
  - 7/-2 -> quo=0xFFFD, rem=1
  - -7/-2 -> quo=3, rem=0xFFFF
- Fairness: all 4 requesters continuously valid from reset -> grant order 0,1,2,3,0; no requester is starved.
- Response backpressure: hold rsp_ready low 5 cycles in RESP -> rsp_quo/rem stable; req_ready stays 0; busy=1 throughout.
- Reset mid-WAIT: assert rst one cycle during WAIT -> no rsp_valid; next cycle ptr=0, state IDLE, all outputs 0.
- Divide by zero, Q=-5, M=0:
  - With DIV_SCHED_DIVZERO_EN: rsp after 1 edge, err=1, quo=0x8000, rem=0xFFFB.
  - Without the macro: rsp after SETTLE_CYCLES edges, err=0.
